tf_step_sequencer: RTL

TF_STEP_SEQUENCER -- requirements
Module: tf_step_sequencer

---
 rtl/tf_step_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tf_step_sequencer.sv
// Step-response sequencer for an emulated filter: resets the filter, settles it at v_init,
// applies v_step and captures decimated v_out samples into a show-ahead FIFO.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for start, filter held out of reset, no clocking
//   S_DUT_RST | one-cycle filter reset with v_init applied
//   S_SETTLE  | filter clocked at v_init for the latched settle count
//   S_RUN     | filter clocked at v_step, every decim-th cycle captured
//   S_DONE    | run complete, filter frozen at v_step, FIFO still readable
module tf_step_sequencer #(
   parameter int WIDTH = 25,
   parameter int CNT_W = 16,
   parameter int DEPTH = 16
) (
   input  logic                    emu_clk,
   input  logic                    emu_rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        settle_cycles,
   input  logic [CNT_W-1:0]        decim,
   input  logic [CNT_W-1:0]        num_samples,
   input  logic signed [WIDTH-1:0] v_init,
   input  logic signed [WIDTH-1:0] v_step,
   output logic signed [WIDTH-1:0] v_in,
   output logic                    filt_cke,
   output logic                    filt_rst,
   input  logic signed [WIDTH-1:0] v_out,
   output logic signed [WIDTH-1:0] sample_data,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow
);

   localparam int              AW     = $clog2(DEPTH);
   localparam logic [AW:0]      C_FULL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DUT_RST,
      S_SETTLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cfg_settle;
   logic [CNT_W-1:0]        r_cfg_dec_m1;
   logic [CNT_W-1:0]        r_cfg_num;
   logic signed [WIDTH-1:0] r_cfg_step;
   logic [CNT_W-1:0]        r_tmr;
   logic [CNT_W-1:0]        r_dec;
   logic [CNT_W-1:0]        r_left;

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [AW:0]             r_count;

   logic w_start_ok;
   logic w_cap;
   logic w_pop;
   logic w_full;
   logic w_wr;

   assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_cap        = (r_state == S_RUN) && (r_dec == '0);
   assign sample_valid = (r_count != '0);
   assign w_pop        = sample_valid && sample_ready;
   assign w_full       = (r_count == C_FULL);
   // A pop on the capture edge frees the slot the new sample lands in.
   assign w_wr         = w_cap && (!w_full || w_pop);
   assign sample_data  = sample_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge emu_clk) begin
      if (emu_rst) begin
         r_state      <= S_IDLE;
         filt_rst     <= 1'b1;
         filt_cke     <= 1'b0;
         v_in         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         r_cfg_settle <= '0;
         r_cfg_dec_m1 <= '0;
         r_cfg_num    <= '0;
         r_cfg_step   <= '0;
         r_tmr        <= '0;
         r_dec        <= '0;
         r_left       <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               filt_rst <= 1'b0;
               if (start) begin
                  r_cfg_settle <= settle_cycles;
                  r_cfg_dec_m1 <= (decim == '0) ? '0 : decim - C_ONE;
                  r_cfg_num    <= num_samples;
                  r_cfg_step   <= v_step;
                  r_state      <= S_DUT_RST;
                  filt_rst     <= 1'b1;
                  filt_cke     <= 1'b0;
                  v_in         <= v_init;
                  busy         <= 1'b1;
                  done         <= 1'b0;
               end
            end
            S_DUT_RST, S_SETTLE: begin
               filt_rst <= 1'b0;
               if (r_state == S_DUT_RST && r_cfg_settle != '0) begin
                  r_state  <= S_SETTLE;
                  r_tmr    <= r_cfg_settle - C_ONE;
                  filt_cke <= 1'b1;
               end else if (r_state == S_SETTLE && r_tmr != '0) begin
                  r_tmr <= r_tmr - C_ONE;
               end else if (r_cfg_num == '0) begin
                  r_state  <= S_DONE;
                  filt_cke <= 1'b0;
                  v_in     <= r_cfg_step;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  r_state  <= S_RUN;
                  filt_cke <= 1'b1;
                  v_in     <= r_cfg_step;
                  r_dec    <= r_cfg_dec_m1;
                  r_left   <= r_cfg_num;
               end
            end
            S_RUN: begin
               if (r_dec == '0) begin
                  r_dec  <= r_cfg_dec_m1;
                  r_left <= r_left - C_ONE;
                  if (r_left == C_ONE) begin
                     r_state  <= S_DONE;
                     filt_cke <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end else begin
                  r_dec <= r_dec - C_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge emu_clk) begin
      if (emu_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else if (w_start_ok) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop) r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
         if (w_cap && w_full && !w_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge emu_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= v_out;
   end

endmodule
